fifo_uart_loader: RTL
=====================

FIFO_UART_LOADER -- requirements
Module: fifo_uart_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the memory address.
REQ-002 SHALL have parameter BASE_ADDR, default 0: address of the first word written.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000: number of idle receive cycles before abort (used only under REQ-030).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load.
- word_count  in  16  number of 32-bit words to load; sampled on start.
- rx_valid  in  1  UART byte strobe, one cycle per byte.
- rx_data  in  8  UART byte; the first byte is the MSB of the word.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data_in  out  8  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_rd_en  out  1  FIFO read request.
- fifo_data_out  in  32  packed word from the FIFO.
- fifo_data_out_valid  in  1  packed word is valid.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory accepted the write.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- overrun_err  out  1  sticky flag: a byte was dropped.
- timeout_err  out  1  sticky flag: a load was aborted on timeout.

Function
REQ-005 SHALL implement FSM states IDLE, FILL, RD_REQ, RD_WAIT, MEM_WR, FINISH.
REQ-006 IDLE: on start with word_count != 0, SHALL latch word_count, set mem_addr to BASE_ADDR, clear both error flags, and go to FILL.
REQ-007 IDLE: on start with word_count == 0, SHALL clear both error flags and pulse done on the next cycle without entering FILL.
REQ-008 In every state except IDLE and FINISH, rx_valid with fifo_full=0 SHALL drive fifo_wr_en=1 and fifo_data_in=rx_data in the same cycle (combinational pass-through).
REQ-009 rx_valid with fifo_full=1 SHALL drop the byte and set overrun_err; the flag holds until the next start.
REQ-010 rx_valid while in IDLE or FINISH SHALL be ignored, with no error flag set.
REQ-011 SHALL keep a 5-bit byte-level counter tracking bytes in the FIFO:
- +1 on every accepted write.
- -4 on every fifo_rd_en pulse.
- Both events in the same cycle: net -3.
REQ-012 FILL -> RD_REQ when the byte-level counter >= 4.
REQ-013 RD_REQ SHALL assert fifo_rd_en for exactly one cycle, then go to RD_WAIT.
REQ-014 RD_WAIT SHALL capture fifo_data_out into mem_wdata when fifo_data_out_valid=1, then go to MEM_WR.
REQ-015 MEM_WR SHALL hold mem_we=1, with mem_addr and mem_wdata stable, until mem_ready=1.
REQ-016 On handshake completion in MEM_WR:
- mem_addr SHALL increment by 4 (wrapping modulo 2^ADDR_W).
- The remaining-word count SHALL decrement.
- Next state: FINISH if the remaining count reaches 0, otherwise FILL.
REQ-017 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 start asserted while busy=1 SHALL be ignored.
REQ-020 Minimum latency from the 4th accepted byte to mem_we is 3 cycles (FILL, RD_REQ, RD_WAIT), given fifo_data_out_valid one cycle after fifo_rd_en.

Reset
REQ-021 rst SHALL force IDLE and clear all counters.
REQ-022 While in reset, all outputs SHALL be 0, except mem_addr, which SHALL equal BASE_ADDR.
REQ-023 rst asserted mid-load SHALL abort immediately with no done pulse; the owner of the FIFO resets it on the same rst.

Configuration
REQ-030 When LOADER_TIMEOUT_EN is defined:
- An idle counter SHALL clear on every accepted byte.
- In FILL it SHALL increment each cycle no byte is accepted.
- At TIMEOUT_CYC it SHALL set timeout_err, skip the done pulse, and go to IDLE.
REQ-031 When LOADER_TIMEOUT_EN is undefined, the idle counter SHALL be absent, timeout_err SHALL be tied to 0, and FILL waits indefinitely.

Structure
REQ-040 The state enum and the constant BYTES_PER_WORD=4 SHALL live in package fifo_uart_pkg.
REQ-041 The byte-level counter SHALL be a separate sub-module, fifo_lvl_cnt, with inputs inc and dec4 and a 5-bit output level.

Verification
REQ-050 word_count=1, bytes A1,B2,C3,D4 -> one mem_we with addr 0x0, wdata 0xA1B2C3D4, then a done pulse.
REQ-051 word_count=3, 12 back-to-back bytes, mem_ready delayed 5 cycles each -> addresses 0x0, 0x4, 0x8; data 0x11223344, 0x55667788, 0x99AABBCC; no error flags.
REQ-052 fifo_full forced to 1 during one rx_valid -> overrun_err=1, byte not written; the flag clears on the next start.
REQ-053 start with word_count=0 -> done pulse on the next cycle; busy stays 0 throughout.
REQ-054 rst pulsed after 2 of 4 bytes -> busy=0, no done pulse; a new start with 4 bytes 0x01020304 loads correctly at 0x0.
REQ-055 With LOADER_TIMEOUT_EN and TIMEOUT_CYC=50: 2 bytes, then silence -> timeout_err=1 at cycle 50 after the last byte, return to IDLE, no done pulse.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and sizing constants for the UART-to-memory FIFO loader.
package fifo_uart_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEVEL_W        = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        MEM_WR  = 3'd4,
        FINISH  = 3'd5
    } loader_state_t;

    // A full word is ready once the FIFO holds four bytes, counting a byte
    // being written this very cycle so the read can be requested next cycle.
    function automatic logic word_available(input logic [LEVEL_W-1:0] level,
                                            input logic                inc);
        return (level >= LEVEL_W'(BYTES_PER_WORD)) ||
               (inc && (level == LEVEL_W'(BYTES_PER_WORD - 1)));
    endfunction

endpackage

// File: rtl/fifo_lvl_cnt.sv
// Byte-level occupancy tracker for the packing FIFO: +1 per byte written,
// -4 per packed word read.
module fifo_lvl_cnt
    import fifo_uart_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec4,
    output logic [LEVEL_W-1:0]  level
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({inc, dec4})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(BYTES_PER_WORD);
                2'b11:   level <= level - LEVEL_W'(BYTES_PER_WORD - 1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fifo_uart_loader.sv
// Streams UART bytes through an external byte-to-word FIFO into memory.
// Define LOADER_TIMEOUT_EN to abort a load after TIMEOUT_CYC idle receive cycles.
module fifo_uart_loader
    import fifo_uart_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       word_count,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              fifo_wr_en,
    output logic [7:0]        fifo_data_in,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    input  logic [31:0]       fifo_data_out,
    input  logic              fifo_data_out_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun_err,
    output logic              timeout_err
);

    loader_state_t      state_reg, state_next;
    logic [15:0]        remaining_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [31:0]        mem_wdata_reg;
    logic               overrun_reg;
    logic               zero_done_reg;
    logic [LEVEL_W-1:0] level;

    logic rx_window;
    logic accept;
    logic drop;
    logic start_ok;
    logic word_ready;
    logic last_word;
    logic timeout_hit;

    // Bytes are only meaningful while a load is actively collecting data.
    assign rx_window  = (state_reg != IDLE) && (state_reg != FINISH);
    assign accept     = rx_window && rx_valid && !fifo_full;
    assign drop       = rx_window && rx_valid && fifo_full;
    assign start_ok   = (state_reg == IDLE) && start;
    assign word_ready = word_available(level, accept);
    assign last_word  = (remaining_reg == 16'd1);

    assign fifo_wr_en   = accept;
    assign fifo_data_in = accept ? rx_data : 8'h00;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign overrun_err  = overrun_reg;

    fifo_lvl_cnt u_lvl_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .dec4  (fifo_rd_en),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start && (word_count != 16'd0)) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (word_ready) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (fifo_data_out_valid) begin
                    state_next = MEM_WR;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_next = last_word ? FINISH : FILL;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        mem_we     = 1'b0;
        fifo_rd_en = 1'b0;
        done       = zero_done_reg;
        case (state_reg)
            IDLE:    busy       = 1'b0;
            RD_REQ:  fifo_rd_en = 1'b1;
            MEM_WR:  mem_we     = 1'b1;
            FINISH:  done       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_reg <= '0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= '0;
            overrun_reg   <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            // An empty load completes without ever leaving IDLE.
            zero_done_reg <= start_ok && (word_count == 16'd0);

            if (start_ok) begin
                overrun_reg <= 1'b0;
                if (word_count != 16'd0) begin
                    remaining_reg <= word_count;
                    mem_addr_reg  <= BASE_ADDR;
                end
            end else if (drop) begin
                overrun_reg <= 1'b1;
            end

            if ((state_reg == RD_WAIT) && fifo_data_out_valid) begin
                mem_wdata_reg <= fifo_data_out;
            end

            if ((state_reg == MEM_WR) && mem_ready) begin
                mem_addr_reg  <= mem_addr_reg + ADDR_W'(BYTES_PER_WORD);
                remaining_reg <= remaining_reg - 16'd1;
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt_reg;
    logic              timeout_reg;

    assign timeout_hit = (state_reg == FILL) && !accept &&
                         (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_reg;

    // Idle time is only measured while waiting for bytes in FILL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if ((state_reg != FILL) || accept) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
            end

            if (start_ok) begin
                timeout_reg <= 1'b0;
            end else if (timeout_hit) begin
                timeout_reg <= 1'b1;
            end
        end
    end
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT_CYC == 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule
